// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;

    modport master (output start, a, b, input busy, done, diff, bout);
    modport slave  (input start, a, b, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, N cycles per result.
module serial_subtractor #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           reset,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  sa, sb, res;
    logic [CW-1:0] cnt;
    logic          br, br_nxt, d;
    logic          busy_r, done_r, bout_r;
    logic          accept, step, last;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, control strobes and the full-subtractor cell
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        d         = sa[0] ^ sb[0] ^ br;
        br_nxt    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(N - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs; result shifts in from the MSB end
    always_ff @(posedge clk) begin
        if (reset) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            bout_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt == RUN);
            done_r <= (state_nxt == DONE);
            if (accept) begin
                sa     <= bus.a;
                sb     <= bus.b;
                br     <= 1'b0;
                cnt    <= '0;
                bout_r <= 1'b0;
            end else if (step) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                br  <= br_nxt;
                cnt <= cnt + CW'(1);
                res <= N'({d, res} >> 1);
                if (last) bout_r <= br_nxt;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.diff = res;
    assign bus.bout = bout_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and table-driven checks of serial_subtractor at N=8 and N=1.
module tb_serial_subtractor;
    localparam int unsigned N = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.N(8)) bus8 ();
    serial_subtractor_if #(.N(1)) bus1 ();

    serial_subtractor #(.N(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    serial_subtractor #(.N(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full N=8 operation: latency, busy width, result, then hold in IDLE
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb, input string name);
        int   cnt;
        int   bcyc;
        logic bout_run;
        bus8.a     = a;
        bus8.b     = b;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        cnt      = 0;
        bcyc     = 0;
        bout_run = 1'b0;
        while (!bus8.done && cnt < 4 * N) begin
            if (bus8.busy) bcyc++;
            if (bus8.bout) bout_run = 1'b1;
            tick();
            cnt++;
        end
        check({name, " latency"}, 32'(cnt), 32'(N));
        check({name, " busy_cycles"}, 32'(bcyc), 32'(N));
        check({name, " bout_in_run"}, 32'(bout_run), 32'd0);
        check({name, " busy_at_done"}, 32'(bus8.busy), 32'd0);
        check({name, " diff"}, 32'(bus8.diff), 32'(ed));
        check({name, " bout"}, 32'(bus8.bout), 32'(eb));
        bus8.a = ~a;
        bus8.b = ~b;
        tick();
        check({name, " done_pulse"}, 32'(bus8.done), 32'd0);
        check({name, " idle_busy"}, 32'(bus8.busy), 32'd0);
        check({name, " diff_hold"}, 32'(bus8.diff), 32'(ed));
        check({name, " bout_hold"}, 32'(bus8.bout), 32'(eb));
    endtask

    task automatic op1(input logic a, input logic b, input logic ed, input logic eb);
        int cnt;
        bus1.a     = a;
        bus1.b     = b;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        cnt = 0;
        while (!bus1.done && cnt < 8) begin
            tick();
            cnt++;
        end
        check("n1 latency", 32'(cnt), 32'd1);
        check("n1 diff", 32'(bus1.diff), 32'(ed));
        check("n1 bout", 32'(bus1.bout), 32'(eb));
        tick();
    endtask

    initial begin
        vec_t       vecs[7];
        logic [7:0] ra, rb;
        logic [7:0] b2b_a[4];
        logic [7:0] b2b_b[4];
        int         cnt;

        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        vecs[4] = '{8'h01, 8'h80, 8'h81, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
        b2b_a = '{8'h5A, 8'h00, 8'hC3, 8'h20};
        b2b_b = '{8'h3C, 8'h01, 8'h42, 8'h21};

        reset      = 1'b1;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset busy", 32'(bus8.busy), 32'd0);
        check("reset done", 32'(bus8.done), 32'd0);
        check("reset diff", 32'(bus8.diff), 32'd0);
        check("reset bout", 32'(bus8.bout), 32'd0);
        tick();

        for (int i = 0; i < 7; i++)
            op8(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout, $sformatf("vec%0d", i));

        // start during RUN with different operands must be ignored
        bus8.a     = 8'h80;
        bus8.b     = 8'h01;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        bus8.a     = 8'h10;
        bus8.b     = 8'h01;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        cnt = 3;
        while (!bus8.done && cnt < 4 * N) begin
            tick();
            cnt++;
        end
        check("ign latency", 32'(cnt), 32'(N));
        check("ign diff", 32'(bus8.diff), 32'h7F);
        check("ign bout", 32'(bus8.bout), 32'd0);
        tick();
        check("ign no_restart", 32'(bus8.busy), 32'd0);

        // reset in the middle of RUN aborts everything
        bus8.a     = 8'h5A;
        bus8.b     = 8'h3C;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        tick();
        check("midrst busy_before", 32'(bus8.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst busy", 32'(bus8.busy), 32'd0);
        check("midrst done", 32'(bus8.done), 32'd0);
        check("midrst diff", 32'(bus8.diff), 32'd0);
        check("midrst bout", 32'(bus8.bout), 32'd0);
        tick();
        check("midrst idle", 32'(bus8.busy | bus8.done), 32'd0);
        op8(8'h09, 8'h03, 8'h06, 1'b0, "post_rst");

        // start held high: a result every N+1 cycles from the operands at each accept
        bus8.a     = b2b_a[0];
        bus8.b     = b2b_b[0];
        bus8.start = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                bus8.a = b2b_a[k+1];
                bus8.b = b2b_b[k+1];
            end else begin
                bus8.start = 1'b0;
            end
            cnt = 0;
            while (!bus8.done && cnt < 4 * N) begin
                tick();
                cnt++;
            end
            check($sformatf("b2b%0d latency", k), 32'(cnt), 32'(N));
            check($sformatf("b2b%0d diff", k), 32'(bus8.diff), 32'(8'(b2b_a[k] - b2b_b[k])));
            check($sformatf("b2b%0d bout", k), 32'(bus8.bout), 32'(b2b_a[k] < b2b_b[k]));
            tick();
            check($sformatf("b2b%0d busy_next", k), 32'(bus8.busy), (k < 3) ? 32'd1 : 32'd0);
        end
        tick();

        // N=1 exhaustive
        op1(1'b0, 1'b0, 1'b0, 1'b0);
        op1(1'b0, 1'b1, 1'b1, 1'b1);
        op1(1'b1, 1'b0, 1'b1, 1'b0);
        op1(1'b1, 1'b1, 1'b0, 1'b0);

        // Random sweep against the {a<b, a-b} reference
        for (int i = 0; i < 1500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8(ra, rb, 8'(ra - rb), ra < rb, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
